// File: rtl/cv32e40p_apu_core_pkg.sv
// APU width constants shared by the core-side and unit-side interfaces,
// plus the arbiter FSM encoding and the tag width used by the arbiter.
package cv32e40p_apu_core_pkg;

  parameter int APU_NARGS_CPU    = 3;
  parameter int APU_WOP_CPU      = 6;
  parameter int APU_NDSFLAGS_CPU = 15;
  parameter int APU_NUSFLAGS_CPU = 5;

  // Tags carry a requester index; wide enough for the largest NUM_REQ (8).
  localparam int APU_ARB_TAG_W = 3;

  // Arbiter FSM encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] apu_arb_state_t;
  localparam apu_arb_state_t ARB_IDLE = 1'b0;
  localparam apu_arb_state_t ARB_WAIT = 1'b1;

endpackage

// File: rtl/cv32e40p_apu_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each outstanding APU operation,
// in grant order. DEPTH must be a power of two so pointers wrap naturally.
module cv32e40p_apu_arb_tag_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = APU_ARB_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full_o    = (cnt_r == (PTR_W+1)'(DEPTH));
    empty_o   = (cnt_r == '0);
    push_ok_s = push_i & ~full_o;
    pop_ok_s  = pop_i & ~empty_o;
    head_o    = mem_r[rd_ptr_r];
  end

  // Storage array; contents need no reset because the count guards reads.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Arbiter sharing one APU among NUM_REQ core-side requesters. A winner is
// picked combinationally, held through a stalled handshake, and its index is
// queued so responses are routed back in grant order.
// Define CV32E40P_APU_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority (lowest index wins).
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [NUM_REQ-1:0]                                core_apu_req_i,
  output logic [NUM_REQ-1:0]                                core_apu_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]       core_apu_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]               core_apu_op_i,
  input  logic [NUM_REQ-1:0][2:0]                           core_apu_type_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]          core_apu_flags_i,
  output logic [NUM_REQ-1:0]                                core_apu_rvalid_o,
  output logic [31:0]                                       core_apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                       core_apu_flags_o,
  output logic                                              apu_req_o,
  input  logic                                              apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]                    apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                            apu_op_o,
  output logic [2:0]                                        apu_type_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                       apu_flags_o,
  input  logic                                              apu_rvalid_i,
  input  logic [31:0]                                       apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                       apu_flags_i,
  output logic                                              busy_o,
  output logic                                              spurious_rsp_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apu_arb_state_t             state_r;
  logic [IDX_W-1:0]           winner_r;
  logic [IDX_W-1:0]           pick_s;
  logic                       found_s;
  logic [IDX_W-1:0]           winner_s;
  logic                       valid_s;
  logic                       req_s;
  logic                       hs_s;
  logic                       pop_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [APU_ARB_TAG_W-1:0]   fifo_head_s;
  logic                       spurious_r;

`ifdef CV32E40P_APU_ARB_RR_EN
  logic [IDX_W-1:0] prio_r;
  int               dist_s;
  int               best_s;

  // Round-robin pick: the asserted request closest at/after the pointer wins.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    best_s  = NUM_REQ;
    dist_s  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i >= int'(prio_r)) ? (i - int'(prio_r)) : (i + NUM_REQ - int'(prio_r));
      if (core_apu_req_i[i] && (dist_s < best_s)) begin
        best_s  = dist_s;
        pick_s  = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

  // Priority pointer moves just past the winner of every handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_r <= '0;
    end else if (hs_s) begin
      prio_r <= (int'(winner_s) == NUM_REQ - 1) ? '0 : winner_s + IDX_W'(1);
    end
  end
`else
  // Fixed priority pick: scanning downward leaves the lowest asserted index.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (core_apu_req_i[i]) begin
        pick_s  = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // While stalled the latched winner is held and its own request qualifies it.
  always_comb begin
    if (state_r == ARB_WAIT) begin
      winner_s = winner_r;
      valid_s  = core_apu_req_i[winner_r];
    end else begin
      winner_s = pick_s;
      valid_s  = found_s;
    end
    req_s = rst_ni & valid_s & ~fifo_full_s;
    hs_s  = req_s & apu_gnt_i;
    pop_s = rst_ni & apu_rvalid_i & ~fifo_empty_s;
  end

  // Output drive; everything is forced low while reset is asserted.
  always_comb begin
    apu_req_o         = req_s;
    apu_operands_o    = rst_ni ? core_apu_operands_i[winner_s] : '0;
    apu_op_o          = rst_ni ? core_apu_op_i[winner_s]       : '0;
    apu_type_o        = rst_ni ? core_apu_type_i[winner_s]     : '0;
    apu_flags_o       = rst_ni ? core_apu_flags_i[winner_s]    : '0;
    core_apu_result_o = rst_ni ? apu_result_i                  : '0;
    core_apu_flags_o  = rst_ni ? apu_flags_i                   : '0;
    busy_o            = rst_ni & ~fifo_empty_s;
    spurious_rsp_o    = rst_ni & spurious_r;
    core_apu_gnt_o    = '0;
    core_apu_rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      core_apu_gnt_o[i]    = hs_s  && (winner_s == IDX_W'(i));
      core_apu_rvalid_o[i] = pop_s && (fifo_head_s == APU_ARB_TAG_W'(i));
    end
  end

  // Arbiter FSM: a stalled request locks the winner until handshake or drop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= ARB_IDLE;
      winner_r <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (req_s && !apu_gnt_i) begin
            state_r  <= ARB_WAIT;
            winner_r <= winner_s;
          end
        end
        ARB_WAIT: begin
          if (hs_s || !valid_s) begin
            state_r <= ARB_IDLE;
          end
        end
        default: state_r <= ARB_IDLE;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      spurious_r <= 1'b0;
    end else if (apu_rvalid_i && fifo_empty_s) begin
      spurious_r <= 1'b1;
    end
  end

  cv32e40p_apu_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (APU_ARB_TAG_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs_s),
    .data_i  (APU_ARB_TAG_W'(winner_s)),
    .pop_i   (pop_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter (NUM_REQ=2, TAG_DEPTH=4). Expected
// values are hand-computed; arbitration expectations follow
// CV32E40P_APU_ARB_RR_EN when it is defined.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NR = 2;
  localparam int TD = 4;

  logic                                    clk = 1'b0;
  logic                                    rst_ni;
  logic [NR-1:0]                           req;
  logic [NR-1:0]                           gnt_o;
  logic [NR-1:0][APU_NARGS_CPU-1:0][31:0]  operands;
  logic [NR-1:0][APU_WOP_CPU-1:0]          op;
  logic [NR-1:0][2:0]                      typ;
  logic [NR-1:0][APU_NDSFLAGS_CPU-1:0]     dflags;
  logic [NR-1:0]                           rvalid_o;
  logic [31:0]                             result_o;
  logic [APU_NUSFLAGS_CPU-1:0]             uflags_o;
  logic                                    apu_req;
  logic                                    apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]          apu_operands;
  logic [APU_WOP_CPU-1:0]                  apu_op;
  logic [2:0]                              apu_type;
  logic [APU_NDSFLAGS_CPU-1:0]             apu_flags;
  logic                                    apu_rvalid;
  logic [31:0]                             apu_result;
  logic [APU_NUSFLAGS_CPU-1:0]             apu_uflags;
  logic                                    busy;
  logic                                    spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .core_apu_req_i      (req),
    .core_apu_gnt_o      (gnt_o),
    .core_apu_operands_i (operands),
    .core_apu_op_i       (op),
    .core_apu_type_i     (typ),
    .core_apu_flags_i    (dflags),
    .core_apu_rvalid_o   (rvalid_o),
    .core_apu_result_o   (result_o),
    .core_apu_flags_o    (uflags_o),
    .apu_req_o           (apu_req),
    .apu_gnt_i           (apu_gnt),
    .apu_operands_o      (apu_operands),
    .apu_op_o            (apu_op),
    .apu_type_o          (apu_type),
    .apu_flags_o         (apu_flags),
    .apu_rvalid_i        (apu_rvalid),
    .apu_result_i        (apu_result),
    .apu_flags_i         (apu_uflags),
    .busy_o              (busy),
    .spurious_rsp_o      (spurious)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    req        = 2'b00;
    apu_gnt    = 1'b0;
    apu_rvalid = 1'b0;
    apu_result = 32'h0;
    apu_uflags = 5'h0;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni     = 1'b0;
    req        = 2'b11;
    apu_gnt    = 1'b1;
    apu_rvalid = 1'b1;
    settle();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL reset_apu_req got %0b exp 0", apu_req); end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt_o); end
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", rvalid_o); end
    checks++; if (apu_op !== 6'h00) begin errors++; $display("FAIL reset_apu_op got %h exp 00", apu_op); end
    tick();
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL reset_spurious got %0b exp 0", spurious); end
    rst_ni = 1'b1;
    idle_inputs();
    settle();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL post_reset_apu_req got %0b exp 0", apu_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b exp 0", busy); end
  endtask

  task automatic test_single;
    do_reset();
    req     = 2'b01;
    apu_gnt = 1'b1;
    settle();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt got %b exp 01", gnt_o); end
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL single_apu_req got %0b exp 1", apu_req); end
    checks++; if (apu_op !== 6'h11) begin errors++; $display("FAIL single_op got %h exp 11", apu_op); end
    checks++; if (apu_operands[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL single_operand got %h exp a5a50001", apu_operands[0]); end
    tick();
    req = 2'b00;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL single_no_rvalid got %b exp 00", rvalid_o); end
    tick();
    tick();
    apu_rvalid = 1'b1;
    apu_result = 32'hDEAD_BEEF;
    apu_uflags = 5'h15;
    settle();
    checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL single_rvalid got %b exp 01", rvalid_o); end
    checks++; if (result_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_result got %h exp deadbeef", result_o); end
    checks++; if (uflags_o !== 5'h15) begin errors++; $display("FAIL single_flags got %h exp 15", uflags_o); end
    tick();
    apu_rvalid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got %0b exp 0", busy); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g [4];
`ifdef CV32E40P_APU_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    do_reset();
    req     = 2'b11;
    apu_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (gnt_o !== exp_g[k]) begin errors++; $display("FAIL arb_gnt[%0d] got %b exp %b", k, gnt_o, exp_g[k]); end
      tick();
    end
    req        = 2'b00;
    apu_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (rvalid_o !== exp_g[k]) begin errors++; $display("FAIL arb_rvalid[%0d] got %b exp %b", k, rvalid_o, exp_g[k]); end
      tick();
    end
    apu_rvalid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_busy got %0b exp 0", busy); end
  endtask

  task automatic test_full;
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    do_reset();
    apu_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req = seq[k];
      settle();
      checks++; if (gnt_o !== seq[k]) begin errors++; $display("FAIL full_gnt[%0d] got %b exp %b", k, gnt_o, seq[k]); end
      tick();
    end
    req = 2'b11;
    settle();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL full_req_blocked got %0b exp 0", apu_req); end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL full_gnt_blocked got %b exp 00", gnt_o); end
    apu_rvalid = 1'b1;
    settle();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL full_req_pop_same got %0b exp 0", apu_req); end
    checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL full_rvalid[0] got %b exp 01", rvalid_o); end
    tick();
    req = 2'b00;
    for (int k = 1; k < 4; k++) begin
      settle();
      checks++; if (rvalid_o !== seq[k]) begin errors++; $display("FAIL full_rvalid[%0d] got %b exp %b", k, rvalid_o, seq[k]); end
      tick();
    end
    apu_rvalid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %0b exp 0", busy); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL full_spurious got %0b exp 0", spurious); end
  endtask

  task automatic test_wait;
    do_reset();
    req = 2'b10;
    settle();
    checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL wait_req got %0b exp 1", apu_req); end
    checks++; if (apu_op !== 6'h22) begin errors++; $display("FAIL wait_op0 got %h exp 22", apu_op); end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL wait_gnt0 got %b exp 00", gnt_o); end
    tick();
    req = 2'b11;
    for (int k = 1; k < 3; k++) begin
      settle();
      checks++; if (apu_op !== 6'h22) begin errors++; $display("FAIL wait_op%0d got %h exp 22", k, apu_op); end
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL wait_gnt%0d got %b exp 00", k, gnt_o); end
      tick();
    end
    apu_gnt = 1'b1;
    settle();
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL wait_gnt_done got %b exp 10", gnt_o); end
    checks++; if (apu_op !== 6'h22) begin errors++; $display("FAIL wait_op_done got %h exp 22", apu_op); end
    tick();
    apu_gnt = 1'b0;
    settle();
    checks++; if (apu_op !== 6'h33) begin errors++; $display("FAIL wait_next_op got %h exp 33", apu_op); end
    tick();
    req     = 2'b10;
    apu_gnt = 1'b1;
    settle();
    checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL wait_drop_req got %0b exp 0", apu_req); end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL wait_drop_gnt got %b exp 00", gnt_o); end
    tick();
    settle();
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL wait_regrant got %b exp 10", gnt_o); end
    checks++; if (apu_op !== 6'h22) begin errors++; $display("FAIL wait_regrant_op got %h exp 22", apu_op); end
    tick();
    req        = 2'b00;
    apu_gnt    = 1'b0;
    apu_rvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (rvalid_o !== 2'b10) begin errors++; $display("FAIL wait_rvalid[%0d] got %b exp 10", k, rvalid_o); end
      tick();
    end
    apu_rvalid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_busy got %0b exp 0", busy); end
  endtask

  task automatic test_spurious;
    do_reset();
    apu_rvalid = 1'b1;
    settle();
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL spur_rvalid got %b exp 00", rvalid_o); end
    tick();
    apu_rvalid = 1'b0;
    settle();
    checks++; if (spurious !== 1'b1) begin errors++; $display("FAIL spur_flag got %0b exp 1", spurious); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy got %0b exp 0", busy); end
    req     = 2'b01;
    apu_gnt = 1'b1;
    tick();
    tick();
    req     = 2'b00;
    apu_gnt = 1'b0;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spur_busy_out got %0b exp 1", busy); end
    checks++; if (spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %0b exp 1", spurious); end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_rst_busy got %0b exp 0", busy); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL spur_rst_flag got %0b exp 0", spurious); end
    apu_rvalid = 1'b1;
    settle();
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL spur_rst_discard got %b exp 00", rvalid_o); end
    tick();
    apu_rvalid = 1'b0;
  endtask

  initial begin
    rst_ni   = 1'b0;
    idle_inputs();
    operands = '0;
    operands[0][0] = 32'hA5A5_0001;
    operands[1][0] = 32'h5A5A_0002;
    op[0]     = 6'h11;
    op[1]     = 6'h22;
    typ[0]    = 3'd1;
    typ[1]    = 3'd2;
    dflags[0] = 15'h0001;
    dflags[1] = 15'h0002;
    tick();
    test_reset();
    test_single();
    test_arbitration();
    test_full();
    op[0] = 6'h33;
    test_wait();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
